// File: rtl/freq_detect.sv
// Frequency-coded carrier detector: measures half-periods of sig_in in clk
// cycles, decodes them to a 4-bit symbol and declares lock after repeats.
module freq_detect #(
  parameter int TOL      = 4,
  parameter int LOCK_CNT = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  output logic [3:0] code,
  output logic       valid,
  output logic       locked,
  output logic       no_carrier
);

  // state   | meaning
  // IDLE    | no carrier; next edge starts acquisition, its period is discarded
  // ACQUIRE | collecting consecutive matching half-periods
  // LOCKED  | symbol in code is stable; valid pulsed once on entry

  localparam int CW = 10;
  localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t        state;
  logic          sync1, sync2, sig_prev;
  logic [CW-1:0] hcnt;
  logic [3:0]    cand;
  logic [MW-1:0] match;

  logic          edge_evt;
  logic          timeout;
  logic [CW:0]   period;
  logic [3:0]    k;
  logic [CW:0]   nominal;
  logic [CW:0]   dev;
  logic          good;
  logic          same_cand;
  logic [3:0]    acq_cand;
  logic [MW-1:0] acq_match;
  logic          acq_lock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sync1    <= sig_in;
      sync2    <= sync1;
      sig_prev <= sync2;
    end
  end

  assign edge_evt = sync2 ^ sig_prev;
  assign timeout  = (hcnt == TMAX) && !edge_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= TMAX;
    end else if (edge_evt) begin
      hcnt <= '0;
    end else if (hcnt < TMAX) begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Round to the nearest multiple of 32 and accept only small deviations.
  assign period  = {1'b0, hcnt} + 1'b1;
  assign k       = 4'((period + 11'd16) >> 5);
  assign nominal = {2'b00, k, 5'b00000};
  assign dev     = (period >= nominal) ? (period - nominal) : (nominal - period);
  assign good    = (k != 4'd0) && (period <= 11'd495) && (dev <= 11'(TOL));

  assign same_cand = (match != '0) && (k == cand);
  assign acq_cand  = same_cand ? cand : k;
  assign acq_match = same_cand ? (match + MW'(1)) : MW'(1);
  assign acq_lock  = (acq_match >= MW'(LOCK_CNT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= '0;
      match      <= '0;
      code       <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      no_carrier <= 1'b1;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_evt) begin
            state      <= ACQUIRE;
            match      <= '0;
            no_carrier <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (edge_evt) begin
            if (good) begin
              cand  <= acq_cand;
              match <= acq_match;
              if (acq_lock) begin
                state  <= LOCKED;
                code   <= acq_cand;
                valid  <= 1'b1;
                locked <= 1'b1;
              end
            end else begin
              match <= '0;
            end
          end else if (timeout) begin
            state      <= IDLE;
            code       <= '0;
            match      <= '0;
            no_carrier <= 1'b1;
          end
        end
        LOCKED: begin
          if (edge_evt) begin
            if (good && (k == code)) begin
              state <= LOCKED;
            end else if (good) begin
              state  <= ACQUIRE;
              cand   <= k;
              match  <= MW'(1);
              locked <= 1'b0;
            end else begin
              state  <= ACQUIRE;
              match  <= '0;
              locked <= 1'b0;
            end
          end else if (timeout) begin
            state      <= IDLE;
            code       <= '0;
            match      <= '0;
            locked     <= 1'b0;
            no_carrier <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          locked     <= 1'b0;
          no_carrier <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/freq_detect.md
FREQ_DETECT -- requirements
Module: freq_detect

Interface
REQ-001 Parameter TOL, default 4: max |measured half-period - code*32| in clk cycles accepted as a valid symbol.
REQ-002 Parameter LOCK_CNT, default 2: consecutive matching valid half-periods required to declare lock.
REQ-003 Parameter TIMEOUT, default 1023: clk cycles without an edge before carrier is declared lost; counter width 10 bits.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sig_in  input  1  received square wave, one half-period = {msb,cnt,5'b0} clk cycles; asynchronous to clk.
REQ-007 code  output  4  recovered symbol {msb,cnt[2:0]}, registered.
REQ-008 valid  output  1  one-cycle pulse when a new code is locked.
REQ-009 locked  output  1  level, high while state is LOCKED.
REQ-010 no_carrier  output  1  level, high while state is IDLE.

Function
REQ-011 sig_in passes through a 2-flop synchronizer; an edge event is any change between the synchronizer output and its previous registered value, either polarity.
REQ-012 Half-period counter: cleared to 0 on an edge-event cycle, else incremented, saturating at TIMEOUT.
REQ-013 On an edge event, measured period P = counter+1 (edges B cycles apart give P = B).
REQ-014 Decode: k = (P+16)>>5 truncated to 4 bits; P is good iff 1 <= k <= 15, P <= 495 and |P - 32k| <= TOL; otherwise bad.
REQ-015 FSM states IDLE, ACQUIRE, LOCKED; registers cand[3:0], match (LOCK_CNT-wide enough).
REQ-016 IDLE: edge event -> ACQUIRE, match=0, P discarded (first edge never measured).
REQ-017 ACQUIRE, good P: if match>0 and k==cand then match+1, else cand=k, match=1; when match reaches LOCK_CNT -> LOCKED, code=cand, valid=1 next cycle.
REQ-018 ACQUIRE, bad P: match=0, stay ACQUIRE.
REQ-019 LOCKED, good P with k==code: stay, no valid pulse, code unchanged.
REQ-020 LOCKED, good P with k!=code: -> ACQUIRE, cand=k, match=1, locked drops next cycle; code holds old value until relock.
REQ-021 LOCKED, bad P: -> ACQUIRE, match=0; code holds.
REQ-022 Any state except IDLE: counter reaching TIMEOUT with no edge -> IDLE, code=0, match=0; timeout has priority over nothing else (edge on same cycle wins, counter clears).
REQ-023 All outputs registered; valid/locked/no_carrier/code update on the clk edge after the deciding edge event.
REQ-024 With LOCK_CNT=2, lock is declared on the 3rd edge event after IDLE.

Reset
REQ-025 rst high: state=IDLE, counter=TIMEOUT, synchronizer and edge registers=0, cand=0, match=0, code=0, valid=0, locked=0, no_carrier=1; takes effect immediately regardless of clk.
REQ-026 rst asserted mid-acquisition or while LOCKED discards all progress; after release first edge event is treated per REQ-016.

Verification
REQ-027 sig_in toggling every 160 cycles from reset -> valid pulse and locked=1, code=4'b0101 after 3rd edge; no further valid pulses while unchanged.
REQ-028 Half-periods 164 then 165 (code 5, TOL=4) -> 164 counted good, 165 bad; steady 165 never locks, no_carrier=0, locked=0.
REQ-029 Locked on code 5, switch to 288-cycle half-periods -> locked=0 one cycle after first 288 edge, code stays 5; relock with code=4'b1001 and valid pulse on second 288 edge.
REQ-030 Locked, sig_in held constant -> 1023 cycles after last edge: locked=0, no_carrier=1, code=0.
REQ-031 Half-periods 16 and 10 (k=1 deviation 16, k=0) -> always bad, never locks; rst pulse while locked on code 7 -> all outputs at reset values same cycle.
